act_lut_interp_pipe: RTL



---
 rtl/act_pkg.sv | 27 ++
 rtl/act_interp_lane.sv | 49 ++++
 rtl/act_lut_interp_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// Shared helpers for the LUT/interpolation activation: fraction-width derivation
// and the default hard-sigmoid table contents.
package act_pkg;

    function automatic int act_frac_w(input int data_w, input int addr_w);
        return data_w - addr_w;
    endfunction

    // Entry value is the hard sigmoid evaluated at the segment's start value x.
    function automatic int act_lut_default(input int idx, input int data_w, input int addr_w);
        int seg;
        int x;
        int v;
        int vmax;
        seg  = (idx >= (1 << (addr_w - 1))) ? idx - (1 << addr_w) : idx;
        x    = seg * (1 << (data_w - addr_w));
        v    = (x >>> 2) + (1 << (data_w - 2));
        vmax = (1 << (data_w - 1)) - 1;
        if (v < 0) begin
            v = 0;
        end else if (v > vmax) begin
            v = vmax;
        end
        return v;
    endfunction

endpackage

// File: rtl/act_interp_lane.sv
// One lane of the interpolator: S2 (difference and product) and S3 (shift and add),
// each stage registered and advanced by the shared pipeline enable.
module act_interp_lane
    import act_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     adv_i,
    input  logic        [FRAC_W-1:0] frac_i,
    input  logic signed [DATA_W-1:0] base_i,
    input  logic signed [DATA_W-1:0] next_i,
    output logic signed [DATA_W-1:0] a_o
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DATA_W + 1 + FRAC_W;

    logic signed [DIFF_W-1:0] diff_d;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [DATA_W-1:0] base_q;
    logic signed [DATA_W-1:0] a_d;
    logic signed [DATA_W-1:0] a_q;

    // Arithmetic shift floors toward -inf; the sum always lies between base and next.
    always_comb begin
        diff_d = DIFF_W'(next_i) - DIFF_W'(base_i);
        prod_d = PROD_W'(diff_d) * PROD_W'($signed({1'b0, frac_i}));
        a_d    = DATA_W'((prod_q >>> FRAC_W) + PROD_W'(base_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            base_q <= '0;
            a_q    <= '0;
        end else if (adv_i) begin
            prod_q <= prod_d;
            base_q <= base_i;
            a_q    <= a_d;
        end
    end

    assign a_o = a_q;

endmodule

// File: rtl/act_lut_interp_pipe.sv
// Multi-lane piecewise-linear activation: shared table, S1 lookup, per-lane S2/S3 interpolation.
// ACT_LUT_WRITE_EN makes the table a writable register file reloaded to defaults on rst.
module act_lut_interp_pipe
    import act_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LANES  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] z_value,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] a
`ifdef ACT_LUT_WRITE_EN
    ,
    input  logic                    lut_we,
    input  logic [ADDR_W-1:0]       lut_waddr,
    input  logic [DATA_W-1:0]       lut_wdata
`endif
);

    localparam int FRAC_W  = act_frac_w(DATA_W, ADDR_W);
    localparam int ENTRIES = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_FLAT = ADDR_W'((1 << (ADDR_W - 1)) - 1);

    logic signed [DATA_W-1:0] lut [ENTRIES];

`ifdef ACT_LUT_WRITE_EN
    logic signed [DATA_W-1:0] lut_q [ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                lut_q[i] <= DATA_W'(act_lut_default(i, DATA_W, ADDR_W));
            end
        end else if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            lut[i] = lut_q[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            lut[i] = DATA_W'(act_lut_default(i, DATA_W, ADDR_W));
        end
    end
`endif

    logic                     adv;
    logic                     v1_q;
    logic                     v2_q;
    logic                     v3_q;
    logic        [ADDR_W-1:0] idx_d  [LANES];
    logic        [FRAC_W-1:0] frac_d [LANES];
    logic        [FRAC_W-1:0] frac_q [LANES];
    logic signed [DATA_W-1:0] base_d [LANES];
    logic signed [DATA_W-1:0] base_q [LANES];
    logic signed [DATA_W-1:0] next_d [LANES];
    logic signed [DATA_W-1:0] next_q [LANES];

    // Top segment is held flat instead of interpolating toward the most-negative entry.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            idx_d[l]  = z_value[l*DATA_W + DATA_W - 1 -: ADDR_W];
            frac_d[l] = z_value[l*DATA_W +: FRAC_W];
            base_d[l] = lut[idx_d[l]];
            next_d[l] = (idx_d[l] == IDX_FLAT) ? lut[idx_d[l]] : lut[idx_d[l] + ADDR_W'(1)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                frac_q[l] <= '0;
                base_q[l] <= '0;
                next_q[l] <= '0;
            end
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            for (int l = 0; l < LANES; l++) begin
                frac_q[l] <= frac_d[l];
                base_q[l] <= base_d[l];
                next_q[l] <= next_d[l];
            end
        end
    end

    assign adv       = !v3_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_interp_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .adv_i  (adv),
            .frac_i (frac_q[g]),
            .base_i (base_q[g]),
            .next_i (next_q[g]),
            .a_o    (a[g*DATA_W +: DATA_W])
        );
    end

endmodule
